// File: rtl/pixel_stream_source.sv
// Raster pixel source: walks a frame stored in a 1-cycle-latency sync RAM and
// emits it row-major as a data/valid stream with optional blanking between lines.
module pixel_stream_source #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       img_width,
  input  logic [11:0]       img_height,
  input  logic [7:0]        hblank_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              line_end,
  output logic              frame_end,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, READ, HBLANK, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [11:0]       col_q, col_d, row_q, row_d;
  logic [11:0]       width_q, width_d, height_q, height_d;
  logic [7:0]        hblank_q, hblank_d, hb_cnt_q, hb_cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Stage 1 tracks the read issued last cycle, stage 2 is the output register.
  // The stream is valid-only: the consumer has no way to stall it.
  logic              rd_pend_q, le_pend_q, fe_pend_q;
  logic              valid_q, le_q, fe_q;
  logic [DATA_W-1:0] data_q;

  logic accept, last_col, last_row;

  assign accept   = start && (img_width != 12'd0) && (img_height != 12'd0);
  assign last_col = (col_q == width_q - 12'd1);
  assign last_row = (row_q == height_q - 12'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      width_q   <= '0;
      height_q  <= '0;
      hblank_q  <= '0;
      hb_cnt_q  <= '0;
      drain_q   <= '0;
      addr_q    <= BASE;
      rd_pend_q <= 1'b0;
      le_pend_q <= 1'b0;
      fe_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      le_q      <= 1'b0;
      fe_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      width_q   <= width_d;
      height_q  <= height_d;
      hblank_q  <= hblank_d;
      hb_cnt_q  <= hb_cnt_d;
      drain_q   <= drain_d;
      addr_q    <= addr_d;
      rd_pend_q <= mem_rd_en;
      le_pend_q <= mem_rd_en && last_col;
      fe_pend_q <= mem_rd_en && last_col && last_row;
      valid_q   <= rd_pend_q;
      le_q      <= le_pend_q;
      fe_q      <= fe_pend_q;
      if (rd_pend_q) data_q <= mem_rd_data;
    end
  end

  // Row-major walk means the RAM address simply advances by one per read.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    width_d  = width_q;
    height_d = height_q;
    hblank_d = hblank_q;
    hb_cnt_d = hb_cnt_q;
    drain_d  = drain_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = READ;
          width_d  = img_width;
          height_d = img_height;
          hblank_d = hblank_len;
          col_d    = '0;
          row_d    = '0;
          drain_d  = '0;
          addr_d   = BASE;
        end
      end
      READ: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_col) begin
          col_d    = '0;
          hb_cnt_d = hblank_q - 8'd1;
          if (last_row) begin
            state_d = DRAIN;
          end else begin
            row_d = row_q + 12'd1;
            if (hblank_q != 8'd0) state_d = HBLANK;
          end
        end else begin
          col_d = col_q + 12'd1;
        end
      end
      HBLANK: begin
        if (hb_cnt_q == 8'd0) state_d = READ;
        else hb_cnt_d = hb_cnt_q - 8'd1;
      end
      DRAIN: begin
        // Two cycles for the last read to reach the output, one for done.
        if (drain_q == 2'd2) state_d = IDLE;
        else drain_d = drain_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en  = (state_q == READ);
    mem_addr   = addr_q;
    done       = (state_q == DRAIN) && (drain_q == 2'd2);
    busy       = (state_q != IDLE) && !done;
    data_out   = data_q;
    data_valid = valid_q;
    line_end   = le_q;
    frame_end  = fe_q;
  end

endmodule
